// File: rtl/axi.sv
// Shared AXI4 encodings plus the write/read FSM state types used by the
// burst memory peripheral.
package axi;

  typedef enum logic [2:0] {
    BURST_FIXED = 3'b001,
    BURST_INCR  = 3'b010,
    BURST_WRAP  = 3'b100
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi4_burst_address_generator.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; flags
// unsupported burst codes and WRAP lengths (those fall back to INCR).
module axi4_burst_address_generator
  import axi::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int LEN_WIDTH     = 5
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]     len,
  input  logic [2:0]               burst,
  output logic [ADDRESS_WIDTH-1:0] next_addr,
  output logic                     illegal
);

  logic [ADDRESS_WIDTH-1:0] incr_addr;
  logic [ADDRESS_WIDTH-1:0] wrap_mask;
  logic [ADDRESS_WIDTH-1:0] wrap_addr;
  logic                     wrap_len_ok;

  // For legal WRAP lengths, len itself equals beats-1, i.e. the wrap mask.
  assign incr_addr   = addr + 1'b1;
  assign wrap_mask   = ADDRESS_WIDTH'(len);
  assign wrap_addr   = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
  assign wrap_len_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                       (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));

  always_comb begin
    next_addr = incr_addr;
    illegal   = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        next_addr = wrap_len_ok ? wrap_addr : incr_addr;
        illegal   = ~wrap_len_ok;
      end
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi4_burst_memory_peripheral.sv
// AXI4 burst slave over a small byte-writable memory with independent
// write (AW/W/B) and read (AR/R) engines and a saturating error counter.
module axi4_burst_memory_peripheral
  import axi::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [LEN_WIDTH-1:0]      awlen,
  input  logic [2:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [LEN_WIDTH-1:0]      arlen,
  input  logic [2:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [7:0]                error_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** ADDRESS_WIDTH;

  // Assert asynchronously, release two clocks after reset_n rises.
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int = rst_pipe[1];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t                 w_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0] w_addr, w_addr_next;
  logic [LEN_WIDTH-1:0]     w_len, w_beat;
  logic [2:0]               w_burst;
  logic                     w_err, w_illegal, w_final, wlast_bad;
  logic                     aw_hs, w_hs, b_hs;

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;
  assign w_final   = (w_beat == w_len);
  assign wlast_bad = wlast ^ w_final;

  axi4_burst_address_generator #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_w_addr_gen (
    .addr     (w_addr),
    .len      (w_len),
    .burst    (w_burst),
    .next_addr(w_addr_next),
    .illegal  (w_illegal)
  );

  always_ff @(posedge clock or negedge rst_int) begin
    if (!rst_int) w_state <= W_IDLE;
    else          w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)            w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_final)  w_state_next = W_RESP;
      W_RESP:  if (b_hs)             w_state_next = W_IDLE;
      default:                       w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
  end

  // Errors accumulate over the burst and are counted once, on the last beat.
  always_ff @(posedge clock or negedge rst_int) begin
    if (!rst_int) begin
      w_addr      <= '0;
      w_len       <= '0;
      w_burst     <= BURST_INCR;
      w_beat      <= '0;
      w_err       <= 1'b0;
      error_count <= '0;
    end else if (aw_hs) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_burst <= awburst;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr_next;
      w_beat <= w_beat + 1'b1;
      w_err  <= w_err | wlast_bad | w_illegal;
      if (w_final && (w_err | wlast_bad | w_illegal) && (error_count != 8'hFF))
        error_count <= error_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b]) mem[w_addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  r_state_t                 r_state, r_state_next;
  logic [ADDRESS_WIDTH-1:0] r_addr, r_addr_next;
  logic [LEN_WIDTH-1:0]     r_len, r_beat;
  logic [2:0]               r_burst;
  logic                     r_illegal, r_final, ar_hs, r_hs;

  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign r_final = (r_beat == r_len);

  axi4_burst_address_generator #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_r_addr_gen (
    .addr     (r_addr),
    .len      (r_len),
    .burst    (r_burst),
    .next_addr(r_addr_next),
    .illegal  (r_illegal)
  );

  always_ff @(posedge clock or negedge rst_int) begin
    if (!rst_int) r_state <= R_IDLE;
    else          r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs)            r_state_next = R_DATA;
      R_DATA: if (r_hs && r_final)  r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = rvalid && r_final;
    rresp   = (rvalid && r_illegal) ? RESP_SLVERR : RESP_OKAY;
  end

  // rdata is loaded on the same edge as any write, so a colliding read sees old data.
  always_ff @(posedge clock or negedge rst_int) begin
    if (!rst_int) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= BURST_INCR;
      r_beat  <= '0;
      rdata   <= '0;
    end else if (ar_hs) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_burst <= arburst;
      r_beat  <= '0;
      rdata   <= mem[araddr];
    end else if (r_hs && !r_final) begin
      r_addr <= r_addr_next;
      r_beat <= r_beat + 1'b1;
      rdata  <= mem[r_addr_next];
    end
  end

endmodule

// File: tb/tb_axi4_burst_memory_peripheral.sv
// Self-checking bench: directed and randomized AXI4 bursts compared against
// a behavioural memory/address model kept in the bench.
module tb_axi4_burst_memory_peripheral;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 5;
  localparam int SW = DW / 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [LW-1:0] awlen = '0;
  logic [2:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [LW-1:0] arlen = '0;
  logic [2:0]    arburst = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [7:0]    error_count;

  always #5 clock = ~clock;

  axi4_burst_memory_peripheral #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .error_count(error_count)
  );

  logic [DW-1:0] model_mem [DEPTH];
  int            model_errs = 0;
  int            tests_run = 0;
  int            tests_failed = 0;
  logic [DW-1:0] wd [32];
  logic [SW-1:0] ws [32];

  // Address of the beat after 'a', straight from the burst rules.
  function automatic int next_model(input int a, input int len, input int burst);
    int beats;
    int base;
    beats = len + 1;
    if (burst == 1) return a;
    if (burst == 4 && (beats == 2 || beats == 4 || beats == 8 || beats == 16)) begin
      base = (a / beats) * beats;
      return base + ((a - base + 1) % beats);
    end
    return (a + 1) % DEPTH;
  endfunction

  function automatic bit err_model(input int len, input int burst);
    return !(burst == 1 || burst == 2 || burst == 4) ||
           (burst == 4 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic write_burst(input int addr, input int len, input int burst,
                             input bit bad_wlast, input string tag);
    int a, cnt, hold;
    logic [1:0] exp_resp;
    @(posedge clock); #1;
    a = addr;
    exp_resp = (err_model(len, burst) || bad_wlast) ? 2'd2 : 2'd0;
    awaddr = AW'(addr); awlen = LW'(len); awburst = 3'(burst); awvalid = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (!awready && cnt < 200) begin @(negedge clock); cnt++; end
    if (awready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL %s aw_timeout: awready=%b required 1", tag, awready);
      awvalid = 1'b0;
      return;
    end
    @(posedge clock); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i];
      wlast = bad_wlast ? (i != len) : (i == len);
      wvalid = 1'b1;
      cnt = 0;
      @(negedge clock);
      while (!wready && cnt < 200) begin @(negedge clock); cnt++; end
      if (wready !== 1'b1) begin
        tests_run++; tests_failed++;
        $display("FAIL %s w_timeout beat %0d: wready=%b required 1", tag, i, wready);
        wvalid = 1'b0;
        return;
      end
      for (int b = 0; b < SW; b++)
        if (ws[i][b]) model_mem[a][b*8 +: 8] = wd[i][b*8 +: 8];
      a = next_model(a, len, burst);
      @(posedge clock); #1 wvalid = 1'b0; wlast = 1'b0;
    end
    if (exp_resp == 2'd2) model_errs = (model_errs < 255) ? model_errs + 1 : 255;
    cnt = 0;
    @(negedge clock);
    while (!bvalid && cnt < 200) begin @(negedge clock); cnt++; end
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin
      tests_failed++;
      $display("FAIL %s bresp: bvalid=%b bresp=%0d required bvalid=1 bresp=%0d",
               tag, bvalid, bresp, exp_resp);
    end
    hold = $urandom_range(0, 2);
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      tests_run++;
      if (bvalid !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s bvalid_hold: bvalid=%b required 1", tag, bvalid);
      end
    end
    bready = 1'b1;
    @(posedge clock); #1 bready = 1'b0;
    @(negedge clock);
    tests_run++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || error_count !== 8'(model_errs)) begin
      tests_failed++;
      $display("FAIL %s b_done: bvalid=%b awready=%b error_count=%0d required 0 1 %0d",
               tag, bvalid, awready, error_count, model_errs);
    end
    $display("[TB] WR %s addr=%0h len=%0d burst=%03b bresp=%0d errs=%0d",
             tag, addr, len, burst, bresp, error_count);
  endtask

  // mode: 0 rready always high, 1 toggling, 2 random
  task automatic read_burst(input int addr, input int len, input int burst,
                            input int mode, input string tag);
    int a, beat, cnt;
    logic [1:0]    exp_resp;
    logic [DW-1:0] held_d;
    logic          held_l;
    bit            stalled;
    @(posedge clock); #1;
    araddr = AW'(addr); arlen = LW'(len); arburst = 3'(burst); arvalid = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (!arready && cnt < 200) begin @(negedge clock); cnt++; end
    if (arready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL %s ar_timeout: arready=%b required 1", tag, arready);
      arvalid = 1'b0;
      return;
    end
    @(posedge clock); #1 arvalid = 1'b0;
    @(negedge clock);
    tests_run++;
    if (rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s latency: rvalid=%b required 1", tag, rvalid);
    end
    a = addr; beat = 0; cnt = 0; stalled = 0;
    exp_resp = err_model(len, burst) ? 2'd2 : 2'd0;
    while (beat <= len && cnt < 200) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cnt % 2) == 0) : 1'($urandom_range(0, 1));
      if (rvalid !== 1'b1) begin
        tests_run++; tests_failed++;
        $display("FAIL %s rvalid_drop beat %0d: rvalid=%b required 1", tag, beat, rvalid);
        break;
      end
      if (rready) begin
        tests_run++;
        if (rdata !== model_mem[a] || rresp !== exp_resp || rlast !== (beat == len)) begin
          tests_failed++;
          $display("FAIL %s beat %0d: rdata=%h rresp=%0d rlast=%b required %h %0d %b",
                   tag, beat, rdata, rresp, rlast, model_mem[a], exp_resp, (beat == len));
        end
        beat++;
        a = next_model(a, len, burst);
      end else begin
        held_d = rdata; held_l = rlast; stalled = 1;
      end
      @(posedge clock);
      @(negedge clock);
      cnt++;
      if (stalled) begin
        tests_run++;
        if (rdata !== held_d || rlast !== held_l || rvalid !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s stall beat %0d: rdata=%h rlast=%b rvalid=%b required %h %b 1",
                   tag, beat, rdata, rlast, rvalid, held_d, held_l);
        end
        stalled = 0;
      end
    end
    rready = 1'b0;
    tests_run++;
    if (beat != len + 1 || rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s r_end: beats=%0d rvalid=%b required %0d 0", tag, beat, rvalid, len + 1);
    end
    $display("[TB] RD %s addr=%0h len=%0d burst=%03b beats=%0d", tag, addr, len, burst, beat);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b100100) begin
      tests_failed++;
      $display("FAIL reset_ready: aw/w/b/ar/r/last=%b required 100100",
               {awready, wready, bvalid, arready, rvalid, rlast});
    end
    tests_run++;
    if (bresp !== 2'd0 || rresp !== 2'd0 || rdata !== '0 || error_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_values: bresp=%0d rresp=%0d rdata=%h errs=%0d required 0 0 0 0",
               bresp, rresp, rdata, error_count);
    end
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (awready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: awready=%b arready=%b bvalid=%b required 1 1 0",
               awready, arready, bvalid);
    end
    $display("[TB] RESET released");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = '1; end
    write_burst(0, 15, 2, 0, "fill");
    read_burst(0, 15, 2, 0, "fill_rd");
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * (i + 1); ws[i] = 4'hF; end
    write_burst(0, 3, 2, 0, "incr");
    read_burst(0, 3, 2, 0, "incr_rd");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(6, 3, 4, 0, "wrap");
    read_burst(6, 3, 4, 0, "wrap_rd");
    read_burst(4, 3, 2, 0, "wrap_lin_rd");
  endtask

  task automatic test_strobe();
    wd[0] = 32'h0; ws[0] = 4'hF;
    write_burst(9, 0, 2, 0, "strb_clr");
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    write_burst(9, 0, 2, 0, "strb");
    tests_run++;
    if (model_mem[9] !== 32'h00BB00DD) begin
      tests_failed++;
      $display("FAIL strobe_model: model=%h required 00bb00dd", model_mem[9]);
    end
    read_burst(9, 0, 1, 0, "strb_rd");
  endtask

  task automatic test_rollover_and_errors();
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(14, 3, 2, 0, "rollover");
    read_burst(14, 3, 2, 0, "rollover_rd");
    write_burst(0, 2, 4, 0, "wrap_len2");
    tests_run++;
    if (error_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL wrap_len2_count: error_count=%0d required 1", error_count);
    end
    read_burst(0, 2, 4, 0, "wrap_len2_rd");
    read_burst(3, 1, 3'b011, 0, "badcode_rd");
    write_burst(8, 3, 2, 1, "bad_wlast");
  endtask

  task automatic test_stall_read();
    read_burst(0, 7, 2, 1, "stall");
  endtask

  task automatic test_read_before_write();
    logic [DW-1:0] old_v, new_v;
    @(posedge clock); #1;
    old_v = model_mem[5]; new_v = ~old_v;
    awaddr = 4'h5; awlen = '0; awburst = 3'b010; awvalid = 1'b1;
    wdata = new_v; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
    @(posedge clock); #1;
    awvalid = 1'b0;
    araddr = 4'h5; arlen = '0; arburst = 3'b010; arvalid = 1'b1;
    @(posedge clock); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    @(negedge clock);
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rbw: rvalid=%b rdata=%h bvalid=%b required 1 %h 1", rvalid, rdata, bvalid, old_v);
    end
    rready = 1'b1; bready = 1'b1;
    @(posedge clock); #1;
    rready = 1'b0; bready = 1'b0;
    model_mem[5] = new_v;
    $display("[TB] RBW addr=5 read=%h", old_v);
    read_burst(5, 0, 2, 0, "rbw_after");
  endtask

  task automatic test_random();
    int addr, len, burst, kind;
    bit bad;
    for (int t = 0; t < 40; t++) begin
      addr = $urandom_range(0, 15);
      burst = (t % 2 == 0) ? (1 << $urandom_range(0, 2)) : $urandom_range(0, 7);
      len = (burst == 4 && $urandom_range(0, 1)) ? ((2 << $urandom_range(0, 3)) - 1)
                                                 : $urandom_range(0, 15);
      kind = $urandom_range(0, 1);
      if (kind == 0) begin
        bad = ($urandom_range(0, 7) == 0);
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        write_burst(addr, len, burst, bad, "rand_wr");
      end else begin
        read_burst(addr, len, burst, 2, "rand_rd");
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit seen_b;
    @(posedge clock); #1;
    awaddr = 4'h3; awlen = 5'd3; awburst = 3'b010; awvalid = 1'b1;
    @(posedge clock); #1 awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = $urandom; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      @(negedge clock);
      tests_run++;
      if (wready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_mid_beat%0d: wready=%b required 1", i, wready);
      end
      model_mem[3 + i] = wdata;
      @(posedge clock); #1 wvalid = 1'b0;
    end
    wdata = $urandom; wvalid = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || error_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_async: awready=%b wready=%b bvalid=%b errs=%0d required 1 0 0 0",
               awready, wready, bvalid, error_count);
    end
    wvalid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    seen_b = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (bvalid !== 1'b0) seen_b = 1;
    end
    tests_run++;
    if (seen_b || awready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_abandon: bvalid_seen=%0d awready=%b required 0 1", seen_b, awready);
    end
    model_errs = 0;
    $display("[TB] RESET mid-burst released");
    read_burst(3, 1, 2, 0, "rst_retain");
  endtask

  task automatic test_saturation();
    wd[0] = '0; ws[0] = '0;
    for (int i = 0; i < 258; i++) write_burst(i % 16, 0, 0, 0, "sat");
    tests_run++;
    if (error_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturation: error_count=%0d required 255", error_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_incr();
    test_wrap();
    test_strobe();
    test_rollover_and_errors();
    test_stall_read();
    test_read_before_write();
    test_random();
    test_reset_mid_burst();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi4_burst_memory_peripheral.md
AXI4_BURST_MEMORY_PERIPHERAL -- requirements
Module: axi4_burst_memory_peripheral

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, word-address width; memory depth 2**ADDRESS_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter LEN_WIDTH, default 5, burst-length field width (AXI4 encoding: beats = len+1).
REQ-004 SHALL have ports, in order: clock  input  1  single clock, all logic on rising edge; one clock, reset is asynchronous and active-low.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 awaddr/awlen/awburst/awvalid  input  ADDRESS_WIDTH/LEN_WIDTH/3/1; awready  output  1: write-address channel.
REQ-007 wdata/wstrb/wlast/wvalid  input  DATA_WIDTH/DATA_WIDTH/8/1/1; wready  output  1: write-data channel.
REQ-008 bresp  output  2; bvalid  output  1; bready  input  1: write-response channel.
REQ-009 araddr/arlen/arburst/arvalid  input  ADDRESS_WIDTH/LEN_WIDTH/3/1; arready  output  1: read-address channel.
REQ-010 rdata  output  DATA_WIDTH; rresp  output  2; rlast/rvalid  output  1; rready  input  1: read-data channel.
REQ-011 error_count  output  8: saturating count of protocol errors.

Function
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM R_IDLE, R_DATA; both independent, concurrent.
REQ-013 awready SHALL be 1 only in W_IDLE; AW handshake latches addr, len, burst, clears beat counter, moves to W_DATA next cycle.
REQ-014 wready SHALL be 1 only in W_DATA; each W handshake writes bytes with wstrb[i]=1 at current address, then advances address and beat counter.
REQ-015 Handshake with beat counter == len SHALL move to W_RESP with bvalid=1; bvalid held until bready, then W_IDLE.
REQ-016 bresp SHALL be OKAY (0) unless an error occurred in the burst, then SLVERR (2).
REQ-017 Write errors: wlast mismatch with final-beat position; unsupported burst code; illegal WRAP length; each SHALL increment error_count once per burst.
REQ-018 arready SHALL be 1 only in R_IDLE; AR handshake latches fields; rvalid=1 with rdata=mem[araddr] on the next cycle (latency 1).
REQ-019 Read SHALL sustain one beat per cycle: on R handshake rdata loads next-address word same edge; rlast=1 on beat len.
REQ-020 R handshake with rlast=1 SHALL return to R_IDLE with rvalid=0; rvalid/rdata/rlast held stable while rready=0.
REQ-021 rresp SHALL be SLVERR for every beat of a burst with unsupported code or illegal WRAP length, else OKAY; data still returned.
REQ-022 FIXED: address constant all beats.
REQ-023 INCR: address+1 per beat, modulo 2**ADDRESS_WIDTH (wraps past top).
REQ-024 WRAP: beats SHALL be 2/4/8/16; next = (addr & ~(beats-1)) | ((addr+1) & (beats-1)); other lengths treated as INCR plus error.
REQ-025 Unsupported burst code (not one-hot FIXED/INCR/WRAP) SHALL be treated as INCR plus error.
REQ-026 Same-cycle read and write to one address SHALL return old data (read-before-write).
REQ-027 error_count SHALL saturate at 255.

Reset
REQ-028 reset_n=0 SHALL asynchronously force: awready=1, wready=0, bvalid=0, bresp=0, arready=1, rvalid=0, rlast=0, rresp=0, rdata=0, error_count=0, FSMs idle.
REQ-029 Reset mid-burst SHALL abandon the burst with no response; memory contents are not reset and are retained.
REQ-030 Reset deassertion SHALL be synchronised internally (2-flop) before FSMs leave idle.

Structure
REQ-031 Package axi SHALL hold burst_t (FIXED=001, INCR=010, WRAP=100) and new resp_t (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
REQ-032 Next-address logic SHALL be sub-module axi4_burst_address_generator (addr, len, burst -> next_addr, illegal flag), shared by both FSMs.

Verification
REQ-033 INCR write addr 0x0, len 3, data 0x11..0x44, strobes 0xF -> bresp OKAY; INCR read addr 0x0 len 3 -> 0x11,0x22,0x33,0x44, rlast on 4th.
REQ-034 WRAP write addr 0x6, len 3 -> words at 6,7,4,5; read back WRAP addr 0x6 len 3 matches; bresp OKAY.
REQ-035 Write 0xAABBCCDD with wstrb 0x5 over 0x00000000 at addr 0x9 -> read 0x00BB00DD.
REQ-036 INCR write addr 0xE len 3 -> words at E,F,0,1; WRAP len 2 request -> SLVERR, error_count=1.
REQ-037 Read len 7 with rready toggling 1/0 each cycle -> 8 beats, rdata stable while stalled, no beat lost.
REQ-038 reset_n pulsed low mid write burst beat 2 -> bvalid never asserted, awready=1 after sync, memory beats 0-1 retained.
